// File: rtl/dpcm_pkg.sv
// dpcm_pkg: constants and types shared by the DPCM decoder and encoder.
//   DPCM_DATA_W    - sample / difference-code width
//   DPCM_BLOCK_LEN - samples per predictor resync block (0 disables resync)
//   DPCM_SAT_MAX   - upper clamp for reconstructed samples
package dpcm_pkg;

  localparam int DPCM_DATA_W    = 8;
  localparam int DPCM_BLOCK_LEN = 16;
  localparam int DPCM_SAT_MAX   = 255;

  typedef logic unsigned [DPCM_DATA_W-1:0] dpcm_sample_t;
  typedef logic signed   [DPCM_DATA_W-1:0] dpcm_code_t;

endpackage

// File: rtl/dpcm_clamp.sv
// dpcm_clamp: combinational sign-extend, add and clamp.
//   pred   in  DATA_W  unsigned predictor
//   code   in  DATA_W  signed two's-complement difference code
//   sample out DATA_W  clamp(pred + code) into [0, SAT_MAX]
//   sat    out 1       clamp engaged (sum < 0 or sum > SAT_MAX)
module dpcm_clamp
  import dpcm_pkg::*;
#(
  parameter int DATA_W  = DPCM_DATA_W,
  parameter int SAT_MAX = DPCM_SAT_MAX
) (
  input  logic [DATA_W-1:0] pred,
  input  logic [DATA_W-1:0] code,
  output logic [DATA_W-1:0] sample,
  output logic              sat
);

  localparam logic signed [DATA_W+1:0] LIM = (DATA_W+2)'(SAT_MAX);

  logic signed [DATA_W+1:0] pred_ext;
  logic signed [DATA_W+1:0] code_ext;
  logic signed [DATA_W+1:0] sum;

  always_comb begin
    // Two guard bits: one for the carry past 2^DATA_W-1, one for the sign.
    pred_ext = $signed({2'b00, pred});
    code_ext = $signed({{2{code[DATA_W-1]}}, code});
    sum      = pred_ext + code_ext;
    sample   = sum[DATA_W-1:0];
    sat      = 1'b0;
    if (sum < 0) begin
      sample = '0;
      sat    = 1'b1;
    end else if (sum > LIM) begin
      sample = DATA_W'(SAT_MAX);
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/dpcm_decoder.sv
// dpcm_decoder: reconstructs unsigned samples from signed DPCM difference
// codes with clamping and periodic predictor resync.
//   clk, rst   clock, synchronous active-high reset
//   Valid      in   upstream code valid
//   Ready      out  decoder can accept a code this cycle
//   DataIn     in   signed difference code
//   OutValid   out  DataOut holds a reconstructed sample
//   OutReady   in   downstream accepts DataOut this cycle
//   DataOut    out  reconstructed sample (retains value while OutValid=0)
//   SatCount   out  saturating clamp-event counter, only when the macro
//                   DPCM_DEC_SAT_CNT_EN is defined
module dpcm_decoder
  import dpcm_pkg::*;
#(
  parameter int DATA_W    = DPCM_DATA_W,
  parameter int BLOCK_LEN = DPCM_BLOCK_LEN,
  parameter int SAT_MAX   = DPCM_SAT_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Valid,
  output logic              Ready,
  input  logic [DATA_W-1:0] DataIn,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] DataOut
`ifdef DPCM_DEC_SAT_CNT_EN
  ,
  output logic [15:0]       SatCount
`endif
);

  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int LAST  = (BLOCK_LEN > 0) ? BLOCK_LEN - 1 : 0;

  logic [DATA_W-1:0] pred;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sample;
  logic              sat;
  logic              accept;

  dpcm_clamp #(
    .DATA_W (DATA_W),
    .SAT_MAX(SAT_MAX)
  ) u_clamp (
    .pred  (pred),
    .code  (DataIn),
    .sample(sample),
    .sat   (sat)
  );

  assign Ready  = ~OutValid | OutReady;
  assign accept = Valid & Ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      OutValid <= 1'b0;
      DataOut  <= '0;
      pred     <= '0;
      cnt      <= '0;
    end else if (accept) begin
      DataOut  <= sample;
      OutValid <= 1'b1;
      // Last code of a block: the output still carries its sample, but the
      // next code is decoded against a zero predictor.
      if (BLOCK_LEN > 0 && cnt == CNT_W'(LAST)) begin
        cnt  <= '0;
        pred <= '0;
      end else begin
        pred <= sample;
        if (BLOCK_LEN > 0) cnt <= cnt + 1'b1;
      end
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

`ifdef DPCM_DEC_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      SatCount <= '0;
    end else if (accept && sat && SatCount != 16'hFFFF) begin
      SatCount <= SatCount + 16'd1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat;
`endif

endmodule

// File: tb/tb_dpcm_decoder.sv
// tb_dpcm_decoder: directed self-checking bench for dpcm_decoder.
// A second instance with BLOCK_LEN=4 shares the stimulus to exercise short
// resync blocks. Build with DPCM_DEC_SAT_CNT_EN to also check SatCount.
module tb_dpcm_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data_in = '0;
  logic       out_ready = 1'b1;

  logic       ready, out_valid;
  logic [7:0] data_out;
  logic       ready4, out_valid4;
  logic [7:0] data_out4;
`ifdef DPCM_DEC_SAT_CNT_EN
  logic [15:0] sat_count, sat_count4;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dpcm_decoder dut (
    .clk(clk), .rst(rst), .Valid(valid), .Ready(ready), .DataIn(data_in),
    .OutValid(out_valid), .OutReady(out_ready), .DataOut(data_out)
`ifdef DPCM_DEC_SAT_CNT_EN
    , .SatCount(sat_count)
`endif
  );

  dpcm_decoder #(.BLOCK_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .Valid(valid), .Ready(ready4), .DataIn(data_in),
    .OutValid(out_valid4), .OutReady(out_ready), .DataOut(data_out4)
`ifdef DPCM_DEC_SAT_CNT_EN
    , .SatCount(sat_count4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; out_ready = 1'b1; data_in = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_outvalid got %b want 0", out_valid); else passed++;
    checks++; if (data_out !== 8'd0) $display("FAIL reset_dataout got %0d want 0", data_out); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
    checks++; if (out_valid4 !== 1'b0) $display("FAIL reset_outvalid4 got %b want 0", out_valid4); else passed++;
`ifdef DPCM_DEC_SAT_CNT_EN
    checks++; if (sat_count !== 16'd0) $display("FAIL reset_satcount got %0d want 0", sat_count); else passed++;
`endif
  endtask

  task automatic test_basic();
    logic [7:0] codes [3] = '{8'd10, 8'd5, 8'hFD};
    logic [7:0] exp   [3] = '{8'd10, 8'd15, 8'd12};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; data_in = codes[i];
      #1;
      checks++; if (ready !== 1'b1) $display("FAIL basic_ready[%0d] got %b want 1", i, ready); else passed++;
      tick();
      checks++; if (out_valid !== 1'b1 || data_out !== exp[i])
        $display("FAIL basic_out[%0d] got v=%b d=%0d want v=1 d=%0d", i, out_valid, data_out, exp[i]);
      else passed++;
    end
    valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || data_out !== 8'd12)
      $display("FAIL basic_drain got v=%b d=%0d want v=0 d=12", out_valid, data_out);
    else passed++;
  endtask

  task automatic test_saturation();
    // 127 -> 127, +123 -> 250, +20 -> 255 (sat), -128 -> 127, -122 -> 5, -20 -> 0 (sat)
    logic [7:0] codes [6] = '{8'd127, 8'd123, 8'd20, 8'h80, 8'h86, 8'hEC};
    logic [7:0] exp   [6] = '{8'd127, 8'd250, 8'd255, 8'd127, 8'd5, 8'd0};
    int         sexp  [6] = '{0, 0, 1, 1, 1, 2};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1; data_in = codes[i];
      tick();
      checks++; if (data_out !== exp[i]) $display("FAIL sat_out[%0d] got %0d want %0d", i, data_out, exp[i]); else passed++;
`ifdef DPCM_DEC_SAT_CNT_EN
      checks++; if (sat_count !== 16'(sexp[i])) $display("FAIL sat_count[%0d] got %0d want %0d", i, sat_count, sexp[i]); else passed++;
`else
      if (sexp[i] < 0) $display("unreachable");
`endif
    end
    valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    valid = 1'b1; data_in = 8'd7;
    tick();
    out_ready = 1'b0; data_in = 8'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b want 0", i, ready); else passed++;
      tick();
      checks++; if (out_valid !== 1'b1 || data_out !== 8'd7)
        $display("FAIL bp_hold[%0d] got v=%b d=%0d want v=1 d=7", i, out_valid, data_out);
      else passed++;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", ready); else passed++;
    tick();
    checks++; if (out_valid !== 1'b1 || data_out !== 8'd11)
      $display("FAIL bp_replace got v=%b d=%0d want v=1 d=11", out_valid, data_out);
    else passed++;
    valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_resync();
    logic [7:0] codes [5] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd7};
    logic [7:0] exp4  [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd7};
    logic [7:0] exp16 [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd11};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; data_in = codes[i];
      tick();
      checks++; if (data_out4 !== exp4[i]) $display("FAIL resync4[%0d] got %0d want %0d", i, data_out4, exp4[i]); else passed++;
      checks++; if (data_out !== exp16[i]) $display("FAIL noresync16[%0d] got %0d want %0d", i, data_out, exp16[i]); else passed++;
    end
    // Default block of 16: codes of 1 give 1..16, then code 5 decodes absolute.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      valid = 1'b1; data_in = 8'd1;
      tick();
      checks++; if (data_out !== 8'(i + 1)) $display("FAIL resync16_ramp[%0d] got %0d want %0d", i, data_out, i + 1); else passed++;
    end
    data_in = 8'd5;
    tick();
    checks++; if (data_out !== 8'd5) $display("FAIL resync16_abs got %0d want 5", data_out); else passed++;
    valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid = 1'b1; data_in = 8'd100;
    tick();
    valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || data_out !== 8'd100)
      $display("FAIL mid_pre got v=%b d=%0d want v=1 d=100", out_valid, data_out);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_outvalid got %b want 0", out_valid); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL mid_ready got %b want 1", ready); else passed++;
    out_ready = 1'b1; valid = 1'b1; data_in = 8'd3;
    tick();
    checks++; if (data_out !== 8'd3) $display("FAIL mid_after got %0d want 3", data_out); else passed++;
    valid = 1'b0;
  endtask

  task automatic test_extreme();
    do_reset();
    valid = 1'b1; data_in = 8'h80;
    tick();
    checks++; if (data_out !== 8'd0) $display("FAIL ext_neg got %0d want 0", data_out); else passed++;
`ifdef DPCM_DEC_SAT_CNT_EN
    checks++; if (sat_count !== 16'd1) $display("FAIL ext_satcount got %0d want 1", sat_count); else passed++;
`endif
    data_in = 8'd127;
    tick();
    checks++; if (data_out !== 8'd127) $display("FAIL ext_pos got %0d want 127", data_out); else passed++;
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_resync();
    test_reset_mid();
    test_extreme();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dpcm_decoder.md
Name: dpcm_decoder

Overview:
- Receive-side counterpart of the DPCM encoder.
- Accepts a stream of signed 8-bit difference codes and reconstructs unsigned 8-bit samples by accumulating them onto a running predictor.
- Clamps each reconstructed sample to the sample range and periodically resynchronises the predictor to zero so that channel errors cannot propagate forever.
- Sits between the link receiver (upstream Valid/Ready) and the sample sink (downstream OutValid/OutReady).

Parameters:
- DATA_W, 8, width of samples and of difference codes.
- BLOCK_LEN, 16, number of samples per resync block; the predictor is forced to 0 after every BLOCK_LEN accepted codes; 0 disables resync.
- SAT_MAX, 255, upper clamp for reconstructed samples; must be at most 2^DATA_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- Valid  in  1  upstream code valid.
- Ready  out  1  decoder can accept a code this cycle.
- DataIn  in  DATA_W  signed two's-complement difference code.
- OutValid  out  1  DataOut holds a reconstructed sample.
- OutReady  in  1  downstream accepts DataOut this cycle.
- DataOut  out  DATA_W  reconstructed unsigned sample.
- SatCount  out  16  saturation event counter; present only with DPCM_DEC_SAT_CNT_EN.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: OutValid=0, DataOut=0, predictor=0, block counter=0, SatCount=0. Ready is 1 on the first cycle after reset release.
- Ready is combinational: Ready = ~OutValid | OutReady. It must never depend on Valid.
- Accept: a code is accepted when Valid && Ready.
- Reconstruction:
  - sum = predictor + sign_extend(DataIn), computed at DATA_W+2 bits signed.
  - If sum < 0, sample = 0.
  - Else if sum > SAT_MAX, sample = SAT_MAX.
  - Else sample = sum.
- Latency and throughput:
  - On the accept edge: DataOut <= sample, OutValid <= 1, predictor <= sample.
  - Latency is 1 cycle. Throughput is 1 sample per cycle while OutReady=1.
- Output hold:
  - While OutValid && ~OutReady, DataOut, predictor and counter hold.
  - Ready=0 in this condition, so no code is lost.
- Drain: if OutValid && OutReady && ~(Valid && Ready), then OutValid <= 0 on the next edge.
- Simultaneous drain and accept: the new sample replaces the old one in the same edge and OutValid stays 1.
- Resync (BLOCK_LEN > 0):
  - The block counter increments on each accept.
  - On the accept where counter == BLOCK_LEN-1: counter <= 0 and predictor <= 0.
  - DataOut still carries that accept's sample. The next code is applied to predictor 0, i.e. it is an absolute value.
- BLOCK_LEN == 0: the counter is held at 0 and no resync ever occurs.
- Reset mid-operation: rst wins over all other events. A pending output is discarded (OutValid=0) and the predictor is zeroed, so the next block starts fresh.
- DataOut is a don't-care while OutValid=0, but it must retain its last value; it must not toggle.

Optional Feature:
- Macro: DPCM_DEC_SAT_CNT_EN.
- Defined:
  - Port SatCount exists and resets to 0.
  - It increments by 1 on each accept where the clamp engaged (sum < 0 or sum > SAT_MAX).
  - It saturates at 16'hFFFF and does not wrap.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Decomposition:
- Package dpcm_pkg holds:
  - constants DPCM_DATA_W=8, DPCM_BLOCK_LEN=16, DPCM_SAT_MAX=255, shared with the encoder;
  - typedef dpcm_sample_t (logic unsigned [DPCM_DATA_W-1:0]);
  - typedef dpcm_code_t (logic signed [DPCM_DATA_W-1:0]).
- One sub-module is natural: dpcm_clamp, a combinational sign-extend, add and clamp returning the sample plus a sat flag. It is reused by any future signed encoder.
- The handshake, predictor and counter stay in dpcm_decoder.

Test Plan:
- Reset, then codes 10, 5, -3 with OutReady=1 -> DataOut 10, 15, 12 on consecutive cycles, one cycle after each accept; Ready stays 1.
- Predictor 250, code +20 -> DataOut 255, SatCount 1. Predictor 5, code -20 -> DataOut 0, SatCount 2.
- Backpressure: OutReady=0 for 3 cycles with Valid=1 -> Ready=0, DataOut held, no code consumed. OutReady=1 -> the held sample drains and the next code is accepted in the same cycle.
- BLOCK_LEN=4, codes 1,1,1,1,7 -> DataOut 1,2,3,4,7; the fifth output reflects the predictor reset to 0.
- rst asserted while OutValid=1 and predictor=100 -> next cycle OutValid=0, Ready=1. Code 3 -> DataOut 3.
- Code -128 applied to predictor 0, then code 127 -> DataOut 0 then 127. This checks sign extension at the negative extreme.
